hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Stall/flush controller for the 5-stage RISC-V pipeline, complementing the EX-stage forwarding unit. Forwarding bypasses results that already exist. This block handles the hazards that forwarding cannot resolve: load-use dependencies, taken-branch wrong-path fetches, and data-memory wait states. It drives the write-enable and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-wait cycles before fatal error (≥2)
- CNT_W, 32: performance counter width
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- IFID_rs1, IFID_rs2  in  5 each  source registers of instruction in ID
- IFID_uses_rs1, IFID_uses_rs2  in  1 each  instruction in ID reads rs1/rs2
- IDEX_rd  in  5  destination of instruction in EX
- IDEX_MemRead  in  1  instruction in EX is a load
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  stage register enables
- ifid_flush  out  1  zero IF/ID contents
- idex_bubble  out  1  load zero control into ID/EX
- memwb_bubble  out  1  load zero control into MEM/WB
- mem_error  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_W  cycles with load-use or memory stall
- flush_count  out  CNT_W  number of branch flushes
- state  out  2  FSM state (debug)

## Operation
- load_use = IDEX_MemRead & (IDEX_rd≠0) & ((IFID_uses_rs1 & IDEX_rd==IFID_rs1) | (IFID_uses_rs2 & IDEX_rd==IFID_rs2)). Suppressed while in LOAD_STALL.
- freeze = (mem_req & ~dmem_ready) | (state==ERROR).
- Priority: freeze > branch_taken > load_use.
- Freeze: all four enables 0, memwb_bubble=1, flush/idex_bubble=0.
- Branch (no freeze): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, idex_write=1, exmem_write=1. The wrong-path load_use is ignored.
- Load-use (no freeze, no branch): pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1, exmem_write=1.
- Otherwise: all enables 1, all flush/bubble 0.
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2, ERROR=3 (held in a shared package).
- RUN: freeze→MEM_WAIT; else load_use & ~branch_taken→LOAD_STALL; else RUN.
- LOAD_STALL: freeze→MEM_WAIT; else RUN.
- MEM_WAIT: freeze→MEM_WAIT; else RUN. In the releasing cycle, outputs decode as in RUN.
- wait_cnt counts consecutive freeze cycles and clears on any non-freeze cycle. When it reaches MEM_TIMEOUT-1 with freeze still true, the next state is ERROR.
- ERROR is sticky until reset. mem_error=1 in ERROR; the pipeline stays frozen.
- stall_cycles: +1 on each edge where freeze or an active load-use stall held, ERROR included.
- flush_count: +1 on each edge where a branch flush was issued.
- Both counters saturate at all-ones.

## Timing
- All control outputs are combinational from registered state plus current inputs; they act in the same cycle.
- State, wait_cnt and counters update on the rising clk edge.
- While reset=1 (synchronous, sampled at the edge):
  - outputs forced: pc_write=ifid_write=idex_write=exmem_write=0, ifid_flush=idex_bubble=memwb_bubble=1, mem_error=0
  - at the edge: state→RUN, wait_cnt and counters→0
- Reset mid-stall or in ERROR: the next cycle decodes as RUN with fresh inputs.
- A load-use stall lasts exactly one cycle. A following dependent instruction in ID is re-checked against the new EX.
- Branch plus freeze in the same cycle: freeze wins. The branch is re-presented after release because EX is held.
- dmem_ready=1 in the first mem_req cycle gives no stall.

## Structure
- Shared package: state encoding constants, MEM_TIMEOUT default, and the pipeline-control bundle ordering.
- Sub-module sat_counter (width CNT_W, inc, clear) is instantiated twice for stall_cycles and flush_count.
- The FSM, wait_cnt and output decode live in the top module.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5, uses_rs2=1 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; state 0→1→0; stall_cycles=1.
- rd=0 / unused operand: IDEX_rd=0, or rs2 match with uses_rs2=0 → no stall, all enables 1.
- Branch vs load-use: branch_taken=1 together with a load-use match → ifid_flush=1, pc_write=1, no LOAD_STALL; flush_count=1.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 → 3 frozen cycles, memwb_bubble=1, state=2, then RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → state=3 after 4 freeze edges, mem_error=1 sticky; reset pulse → state=0, counters=0, mem_error=0.
- Saturation: CNT_W=4, 20 stall cycles → stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit.
//   - FSM state encoding (RUN/LOAD_STALL/MEM_WAIT/ERROR)
//   - default memory timeout
//   - pipeline-control bundle ordering and the fixed bundles for each decode case
package hazard_control_unit_pkg;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2,
        StError     = 2'd3
    } hcu_state_e;

    // Bundle order, MSB first: enables, then flush/bubble controls.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RESET    = pipe_ctrl_t'(7'b0000_111);
    localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(7'b0000_001);
    localparam pipe_ctrl_t CTRL_BRANCH   = pipe_ctrl_t'(7'b1111_110);
    localparam pipe_ctrl_t CTRL_LOAD_USE = pipe_ctrl_t'(7'b0011_010);
    localparam pipe_ctrl_t CTRL_RUN      = pipe_ctrl_t'(7'b1111_000);

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the hazard unit's performance counters.
// Ports:
//   clk_i   - clock, rising edge
//   clear_i - synchronous clear, takes priority over inc_i
//   inc_i   - add one on this edge unless already all-ones
//   count_o - current count
module hazard_control_unit_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline. Resolves hazards that forwarding
// cannot: load-use dependencies, taken-branch wrong-path fetches and data-memory waits.
// Ports:
//   clk, reset (sync, active-high)
//   IFID_rs1/rs2, IFID_uses_rs1/rs2 - operands of the instruction in ID
//   IDEX_rd, IDEX_MemRead           - destination / load flag of the instruction in EX
//   branch_taken                    - EX resolved a taken branch this cycle
//   mem_req, dmem_ready             - MEM-stage data access handshake
//   pc_write..exmem_write           - stage register enables
//   ifid_flush, idex_bubble, memwb_bubble - squash controls
//   mem_error                       - sticky memory timeout flag
//   stall_cycles, flush_count       - saturating performance counters
//   state                           - FSM state for debug
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_uses_rs1,
    input  logic             IFID_uses_rs2,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_MemRead,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);

    hcu_state_e       state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

    logic       load_use_hit;
    logic       load_use;
    logic       freeze;
    logic       timeout;
    logic       stall_inc;
    logic       flush_inc;
    pipe_ctrl_t ctrl;

    always_comb begin
        load_use_hit = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                       ((IFID_uses_rs1 && (IDEX_rd == IFID_rs1)) ||
                        (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));
        // The stalled instruction would re-match the same load; the bubble resolves it.
        load_use     = load_use_hit && (state_q != StLoadStall);
        freeze       = (mem_req && !dmem_ready) || (state_q == StError);
        timeout      = freeze && (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1));
    end

    // Next state and wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = freeze ? wait_cnt_q + 1'b1 : '0;
        if (timeout) begin
            wait_cnt_d = wait_cnt_q;
        end
        unique case (state_q)
            StRun: begin
                if (timeout) begin
                    state_d = StError;
                end else if (freeze) begin
                    state_d = StMemWait;
                end else if (load_use && !branch_taken) begin
                    state_d = StLoadStall;
                end else begin
                    state_d = StRun;
                end
            end
            StLoadStall, StMemWait: begin
                if (timeout) begin
                    state_d = StError;
                end else if (freeze) begin
                    state_d = StMemWait;
                end else begin
                    state_d = StRun;
                end
            end
            StError: state_d = StError;
            default: state_d = StRun;
        endcase
    end

    // Output decode: freeze > branch > load-use
    always_comb begin
        ctrl = CTRL_RUN;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign idex_write   = ctrl.idex_write;
    assign exmem_write  = ctrl.exmem_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign mem_error    = !reset && (state_q == StError);
    assign state        = state_q;

    assign stall_inc = !reset && (freeze || (load_use && !branch_taken));
    assign flush_inc = !reset && !freeze && branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    hazard_control_unit_sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .clear_i (reset),
        .inc_i   (stall_inc),
        .count_o (stall_cycles)
    );

    hazard_control_unit_sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk),
        .clear_i (reset),
        .inc_i   (flush_inc),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
    logic       IFID_uses_rs1, IFID_uses_rs2, IDEX_MemRead;
    logic       branch_taken, mem_req, dmem_ready;
    logic       pc_write, ifid_write, idex_write, exmem_write;
    logic       ifid_flush, idex_bubble, memwb_bubble, mem_error;
    logic [3:0] stall_cycles, flush_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .IFID_rs1      (IFID_rs1),
        .IFID_rs2      (IFID_rs2),
        .IFID_uses_rs1 (IFID_uses_rs1),
        .IFID_uses_rs2 (IFID_uses_rs2),
        .IDEX_rd       (IDEX_rd),
        .IDEX_MemRead  (IDEX_MemRead),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_write    (idex_write),
        .exmem_write   (exmem_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .memwb_bubble  (memwb_bubble),
        .mem_error     (mem_error),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .state         (state)
    );

    // {pc, ifid, idex, exmem, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [6:0] C_RST = 7'b0000_111;
    localparam logic [6:0] C_FRZ = 7'b0000_001;
    localparam logic [6:0] C_BR  = 7'b1111_110;
    localparam logic [6:0] C_LU  = 7'b0011_010;
    localparam logic [6:0] C_RUN = 7'b1111_000;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, mreq, rdy;
        logic [6:0] ctrl;
        logic [1:0] nstate;
        logic [3:0] nstall, nflush;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [6:0] ctrl_now();
        return {pc_write, ifid_write, idex_write, exmem_write,
                ifid_flush, idex_bubble, memwb_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IFID_rs1 = 0; IFID_rs2 = 0; IDEX_rd = 0;
        IFID_uses_rs1 = 0; IFID_uses_rs2 = 0; IDEX_MemRead = 0;
        branch_taken = 0; mem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic br, input logic mreq,
                                input logic rdy, input logic [6:0] c, input logic [1:0] ns,
                                input logic [3:0] st, input logic [3:0] fl);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.br = br; v.mreq = mreq; v.rdy = rdy;
        v.ctrl = c; v.nstate = ns; v.nstall = st; v.nflush = fl;
        return v;
    endfunction

    initial begin
        //               name          rs1 u1 rs2 u2 rd mr br mq rdy ctrl   ns st fl
        vecs[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
        vecs[1]  = mk("lu_rs2",        1, 1, 5, 1, 5, 1, 0, 0, 0, C_LU,  1, 1, 0);
        vecs[2]  = mk("lu_rs1",        7, 1, 3, 1, 7, 1, 0, 0, 0, C_LU,  1, 1, 0);
        vecs[3]  = mk("rd_zero",       0, 1, 0, 1, 0, 1, 0, 0, 0, C_RUN, 0, 0, 0);
        vecs[4]  = mk("rs2_unused",    1, 1, 5, 0, 5, 1, 0, 0, 0, C_RUN, 0, 0, 0);
        vecs[5]  = mk("not_load",      1, 1, 5, 1, 5, 0, 0, 0, 0, C_RUN, 0, 0, 0);
        vecs[6]  = mk("br_over_lu",    1, 1, 5, 1, 5, 1, 1, 0, 0, C_BR,  0, 0, 1);
        vecs[7]  = mk("freeze",        0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2, 1, 0);
        vecs[8]  = mk("freeze_br",     0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 2, 1, 0);
        vecs[9]  = mk("ready_first",   0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0, 0);
        vecs[10] = mk("freeze_lu",     1, 1, 5, 1, 5, 1, 0, 1, 0, C_FRZ, 2, 1, 0);

        idle_inputs();
        reset = 1'b1;
        #1;
        check("reset_ctrl", 32'(ctrl_now()), 32'(C_RST));
        check("reset_mem_error", 32'(mem_error), 0);
        tick();
        check("reset_state", 32'(state), 0);
        check("reset_stall_cnt", 32'(stall_cycles), 0);
        check("reset_flush_cnt", 32'(flush_count), 0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            IFID_rs1 = vecs[i].rs1; IFID_uses_rs1 = vecs[i].u1;
            IFID_rs2 = vecs[i].rs2; IFID_uses_rs2 = vecs[i].u2;
            IDEX_rd = vecs[i].rd; IDEX_MemRead = vecs[i].mr;
            branch_taken = vecs[i].br; mem_req = vecs[i].mreq; dmem_ready = vecs[i].rdy;
            #1;
            check({vecs[i].name, "_ctrl"}, 32'(ctrl_now()), 32'(vecs[i].ctrl));
            tick();
            check({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].nstate));
            check({vecs[i].name, "_stall"}, 32'(stall_cycles), 32'(vecs[i].nstall));
            check({vecs[i].name, "_flush"}, 32'(flush_count), 32'(vecs[i].nflush));
        end

        // Load-use lasts one cycle even if the match persists; new EX is re-checked.
        do_reset();
        IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs2 = 5; IFID_uses_rs2 = 1;
        #1;
        check("seq_lu_c1", 32'(ctrl_now()), 32'(C_LU));
        tick();
        check("seq_lu_state1", 32'(state), 1);
        check("seq_lu_c2", 32'(ctrl_now()), 32'(C_RUN));
        tick();
        check("seq_lu_state2", 32'(state), 0);
        check("seq_lu_stall", 32'(stall_cycles), 1);
        IDEX_rd = 6; IFID_rs1 = 6; IFID_uses_rs1 = 1;
        #1;
        check("seq_lu_recheck", 32'(ctrl_now()), 32'(C_LU));
        tick();
        check("seq_lu_stall2", 32'(stall_cycles), 2);

        // Memory wait for three cycles, released on the fourth.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_ctrl", 32'(ctrl_now()), 32'(C_FRZ));
            tick();
            check("mw_state", 32'(state), 2);
        end
        dmem_ready = 1;
        #1;
        check("mw_release_ctrl", 32'(ctrl_now()), 32'(C_RUN));
        tick();
        check("mw_release_state", 32'(state), 0);
        check("mw_stall", 32'(stall_cycles), 3);
        check("mw_no_error", 32'(mem_error), 0);

        // Timeout after four freeze edges, sticky until reset.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        tick(); tick(); tick();
        check("to_state3", 32'(state), 2);
        check("to_err_early", 32'(mem_error), 0);
        tick();
        check("to_state4", 32'(state), 3);
        check("to_err", 32'(mem_error), 1);
        mem_req = 0;
        #1;
        check("to_ctrl_sticky", 32'(ctrl_now()), 32'(C_FRZ));
        tick();
        check("to_state_sticky", 32'(state), 3);
        check("to_err_sticky", 32'(mem_error), 1);
        check("to_stall", 32'(stall_cycles), 5);
        reset = 1;
        #1;
        check("to_rst_ctrl", 32'(ctrl_now()), 32'(C_RST));
        check("to_rst_err", 32'(mem_error), 0);
        tick();
        reset = 0;
        #1;
        check("to_rst_state", 32'(state), 0);
        check("to_rst_stall", 32'(stall_cycles), 0);
        check("to_rst_ctrl_run", 32'(ctrl_now()), 32'(C_RUN));

        // Stall counter saturation (includes ERROR cycles).
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 15; i++) tick();
        check("sat_15", 32'(stall_cycles), 15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_20", 32'(stall_cycles), 15);

        // Flush counter over consecutive branches.
        do_reset();
        branch_taken = 1;
        tick(); tick(); tick();
        check("flush_3", 32'(flush_count), 3);
        check("flush_state", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
